// File: rtl/vector_mem_arbiter_pkg.sv
// Shared types and constants for the vector memory arbiter slice.
package vector_mem_arbiter_pkg;

  // Largest supported requester count; core_id is sized so any legal
  // requester index (up to MAX_NUM_REQ-1) fits.
  localparam int MAX_NUM_REQ = 8;
  localparam int CORE_ID_W   = $clog2(MAX_NUM_REQ);
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;

  // Default per-requester limit on issued-but-unanswered requests.
  localparam int DEFAULT_MAX_OUTSTANDING = 8;

  // One memory transaction; used for requests, the memory port and responses.
  typedef struct packed {
    logic                 vld;
    logic                 we;
    logic [CORE_ID_W-1:0] core_id;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } request_t;

endpackage

// File: rtl/vector_mem_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the search starts one past last_winner
// and wraps modulo NUM_REQ; grant is one-hot, valid flags any winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [IDX_W-1:0] sel;

  // Walk the requesters in priority order and take the first one asserted.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(last_winner) + k) % NUM_REQ);
      if (!valid && req[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one registered memory request port,
// limits each requester's outstanding requests, and routes memory responses
// back to the requester named by core_id.
//
// Handshakes: a requester holds req_in[i].vld (and its payload) until it sees
// req_grant[i]=1 in a cycle; the transfer happens at that clock edge. The
// arbiter holds mem_req (with vld=1) until mem_grant=1 in a cycle; the memory
// takes it at that edge. mem_rsp is never back-pressured: every cycle with
// mem_rsp.vld=1 is one response.
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic               clk,
  input  logic               reset,
  input  request_t           req_in  [NUM_REQ],
  output logic [NUM_REQ-1:0] req_grant,
  output request_t           mem_req,
  input  logic               mem_grant,
  input  request_t           mem_rsp,
  output request_t           rsp_out [NUM_REQ],
  output logic               route_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]     CNT_LIMIT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CORE_ID_W:0]   NUM_REQ_ID = (CORE_ID_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   last_winner;
  logic               armed;
  logic [CNT_W-1:0]   outstanding [NUM_REQ];

  logic               slot_free;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  request_t           win_req;

  logic               rsp_in_range;
  logic [NUM_REQ-1:0] route_hit;
  logic [NUM_REQ-1:0] dec_ok;
  logic               bad_rsp;

  // The output register can take a new request when empty or being accepted.
  assign slot_free = !mem_req.vld || mem_grant;

  // A requester competes only while it is below its outstanding limit; armed
  // suppresses any grant in the first cycle after reset release.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = armed && req_in[i].vld && (outstanding[i] < CNT_LIMIT);
    end
  end

  assign arb_req = eligible & {NUM_REQ{slot_free}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (arb_req),
    .last_winner (last_winner),
    .grant       (win_onehot),
    .valid       (win_valid)
  );

  // The acceptance pulse is the arbiter decision itself, so a requester can
  // present its next request in the very next cycle.
  assign req_grant = win_onehot;

  // Encode the winner and build its request with core_id forced to the index.
  always_comb begin
    win_idx = '0;
    win_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_idx = IDX_W'(i);
        win_req = req_in[i];
      end
    end
    win_req.core_id = CORE_ID_W'(win_idx);
    win_req.vld     = 1'b1;
  end

  // Decode the response target and flag responses that cannot be matched.
  always_comb begin
    rsp_in_range = mem_rsp.vld && ({1'b0, mem_rsp.core_id} < NUM_REQ_ID);
    route_hit    = '0;
    dec_ok       = '0;
    bad_rsp      = mem_rsp.vld && !rsp_in_range;
    for (int i = 0; i < NUM_REQ; i++) begin
      route_hit[i] = rsp_in_range && (mem_rsp.core_id == CORE_ID_W'(i));
      dec_ok[i]    = route_hit[i] && (outstanding[i] != '0);
      if (route_hit[i] && (outstanding[i] == '0)) begin
        bad_rsp = 1'b1;
      end
    end
  end

  // Output request register: load the winner, clear when idle, hold on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req <= '0;
    end else if (slot_free) begin
      mem_req <= win_valid ? win_req : '0;
    end
  end

  // Round-robin pointer moves only on a grant; reset favours requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= LAST_IDX;
    end else if (win_valid) begin
      last_winner <= win_idx;
    end
  end

  // Goes high one edge after reset release and stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Outstanding counters: +1 on grant, -1 on a matched response, net zero
  // when both happen together; a response at zero is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({req_grant[i], dec_ok[i]})
          2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
          2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  // Response routing: only the addressed requester sees the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_out[i] <= route_hit[i] ? mem_rsp : '0;
      end
    end
  end

  // Sticky routing error, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_err <= 1'b0;
    end else if (bad_rsp) begin
      route_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Self-checking bench for vector_mem_arbiter: directed scenarios plus a
// randomized run against a behavioural model.
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  request_t         req_in  [N];
  logic [N-1:0]     req_grant;
  request_t         mem_req;
  logic             mem_grant;
  request_t         mem_rsp;
  request_t         rsp_out [N];
  logic             route_err;

  int n_checks = 0;
  int n_fail   = 0;

  vector_mem_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .req_grant (req_grant),
    .mem_req   (mem_req),
    .mem_grant (mem_grant),
    .mem_rsp   (mem_rsp),
    .rsp_out   (rsp_out),
    .route_err (route_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic request_t mk_req(input logic [2:0] cid, input logic [15:0] addr,
                                      input logic [31:0] data);
    request_t r;
    r         = '0;
    r.vld     = 1'b1;
    r.we      = data[0];
    r.core_id = cid;
    r.addr    = addr;
    r.data    = data;
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) req_in[i] = '0;
    mem_grant = 1'b0;
    mem_rsp   = '0;
  endtask

  // Leaves the DUT out of reset, past its first cycle, at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    req_in[0] = mk_req(3'd0, 16'h0010, 32'h1);
    req_in[2] = mk_req(3'd0, 16'h0020, 32'h2);
    mem_grant = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mem_req !== '0) begin
      n_fail++; $display("FAIL reset_mem_req got=%h exp=0", mem_req);
    end
    n_checks++;
    if (req_grant !== '0) begin
      n_fail++; $display("FAIL reset_grant got=%b exp=0000", req_grant);
    end
    n_checks++;
    if (route_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_route_err got=%b exp=0", route_err);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (rsp_out[i] !== '0) begin
        n_fail++; $display("FAIL reset_rsp_out[%0d] got=%h exp=0", i, rsp_out[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    request_t exp_r;
    int w;
    do_reset();
    mem_grant = 1'b1;
    for (int i = 0; i < 3; i++) req_in[i] = mk_req(3'd7, 16'(256 * i), 32'hA000_0000 + i);
    for (int k = 0; k < 6; k++) begin
      w = k % 3;
      #1;
      n_checks++;
      if (req_grant !== N'(1 << w)) begin
        n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_grant, N'(1 << w));
      end
      exp_r = req_in[w];
      exp_r.core_id = 3'(w);
      @(posedge clk); #1;
      n_checks++;
      if (mem_req !== exp_r) begin
        n_fail++; $display("FAIL rr_mem_req k=%0d got=%h exp=%h", k, mem_req, exp_r);
      end
      @(negedge clk);
      req_in[w] = mk_req(3'd7, 16'(256 * w + k + 1), 32'hB000_0000 + k);
    end
    // Every requester is now at its limit of two.
    #1;
    n_checks++;
    if (req_grant !== '0) begin
      n_fail++; $display("FAIL rr_limit_grant got=%b exp=0000", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req.vld !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle_clear got=%b exp=0", mem_req.vld);
    end
  endtask

  task automatic test_stall();
    request_t exp_r;
    do_reset();
    mem_grant = 1'b0;
    req_in[0] = mk_req(3'd0, 16'h1111, 32'h0000_1110);
    req_in[1] = mk_req(3'd0, 16'h2222, 32'h0000_2220);
    #1;
    n_checks++;
    if (req_grant !== 4'b0001) begin
      n_fail++; $display("FAIL stall_first_grant got=%b exp=0001", req_grant);
    end
    exp_r = req_in[0];
    exp_r.core_id = 3'd0;
    @(negedge clk);
    req_in[0] = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_grant !== '0) begin
        n_fail++; $display("FAIL stall_grant c=%0d got=%b exp=0000", c, req_grant);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_req !== exp_r) begin
        n_fail++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, mem_req, exp_r);
      end
      @(negedge clk);
    end
    mem_grant = 1'b1;
    #1;
    n_checks++;
    if (req_grant !== 4'b0010) begin
      n_fail++; $display("FAIL stall_release_grant got=%b exp=0010", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req.core_id !== 3'd1 || mem_req.addr !== 16'h2222) begin
      n_fail++; $display("FAIL stall_next_req got=%h exp_core=1 exp_addr=2222", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_outstanding_limit();
    int grants;
    do_reset();
    mem_grant = 1'b1;
    req_in[1] = mk_req(3'd0, 16'h0101, 32'h0000_0101);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_grant[1] === 1'b1) grants++;
      @(negedge clk);
    end
    n_checks++;
    if (grants !== 2) begin
      n_fail++; $display("FAIL limit_grant_count got=%0d exp=2", grants);
    end
    mem_rsp = mk_req(3'd1, 16'h0101, 32'h0000_5A5A);
    #1;
    n_checks++;
    if (req_grant !== '0) begin
      n_fail++; $display("FAIL limit_rsp_cycle_grant got=%b exp=0000", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_out[1].vld !== 1'b1 || rsp_out[1].data !== 32'h0000_5A5A) begin
      n_fail++; $display("FAIL limit_rsp_out got=%h exp_data=00005a5a", rsp_out[1]);
    end
    @(negedge clk);
    mem_rsp = '0;
    #1;
    n_checks++;
    if (req_grant !== 4'b0010) begin
      n_fail++; $display("FAIL limit_third_grant got=%b exp=0010", req_grant);
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    do_reset();
    mem_grant = 1'b1;
    req_in[0] = mk_req(3'd0, 16'h0A00, 32'h0000_0A00);
    #1;
    n_checks++;
    if (req_grant !== 4'b0001) begin
      n_fail++; $display("FAIL same_first_grant got=%b exp=0001", req_grant);
    end
    @(negedge clk);
    mem_rsp = mk_req(3'd0, 16'h0A00, 32'hCAFE_0000);
    #1;
    n_checks++;
    if (req_grant !== 4'b0001) begin
      n_fail++; $display("FAIL same_cycle_grant got=%b exp=0001", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_out[0].vld !== 1'b1 || rsp_out[0].data !== 32'hCAFE_0000) begin
      n_fail++; $display("FAIL same_rsp_out0 got=%h exp_data=cafe0000", rsp_out[0]);
    end
    n_checks++;
    if (rsp_out[1].vld !== 1'b0 || rsp_out[2].vld !== 1'b0 || rsp_out[3].vld !== 1'b0) begin
      n_fail++; $display("FAIL same_rsp_others got=%b%b%b exp=000",
                         rsp_out[1].vld, rsp_out[2].vld, rsp_out[3].vld);
    end
    @(negedge clk);
    mem_rsp = '0;
    // Count is still one, so exactly one more grant fits.
    #1;
    n_checks++;
    if (req_grant !== 4'b0001) begin
      n_fail++; $display("FAIL same_after_grant got=%b exp=0001", req_grant);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (req_grant !== '0) begin
      n_fail++; $display("FAIL same_at_limit got=%b exp=0000", req_grant);
    end
    n_checks++;
    if (route_err !== 1'b0) begin
      n_fail++; $display("FAIL same_route_err got=%b exp=0", route_err);
    end
    @(negedge clk);
  endtask

  task automatic test_route_err();
    do_reset();
    mem_rsp = mk_req(3'd5, 16'h5555, 32'h5555_5555);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (rsp_out[i].vld !== 1'b0) begin
        n_fail++; $display("FAIL err_rsp_dropped[%0d] got=%b exp=0", i, rsp_out[i].vld);
      end
    end
    n_checks++;
    if (route_err !== 1'b1) begin
      n_fail++; $display("FAIL err_set got=%b exp=1", route_err);
    end
    @(negedge clk);
    mem_rsp = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (route_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b exp=1", route_err);
    end
    // A response for a requester with nothing outstanding is also an error.
    do_reset();
    n_checks++;
    if (route_err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared got=%b exp=0", route_err);
    end
    mem_rsp = mk_req(3'd2, 16'h0002, 32'h0000_0002);
    @(posedge clk); #1;
    n_checks++;
    if (route_err !== 1'b1) begin
      n_fail++; $display("FAIL err_underflow got=%b exp=1", route_err);
    end
    @(negedge clk);
    mem_rsp = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_grant = 1'b0;
    req_in[2] = mk_req(3'd0, 16'h0202, 32'h0000_0202);
    req_in[3] = mk_req(3'd0, 16'h0303, 32'h0000_0303);
    #1;
    n_checks++;
    if (req_grant !== 4'b0100) begin
      n_fail++; $display("FAIL mid_pre_grant got=%b exp=0100", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req.vld !== 1'b1 || mem_req.core_id !== 3'd2) begin
      n_fail++; $display("FAIL mid_pre_mem_req got=%h exp_core=2", mem_req);
    end
    @(negedge clk);
    req_in[2] = '0;
    req_in[0] = mk_req(3'd0, 16'h0000, 32'h0000_0000);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== '0 || req_grant !== '0 || route_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_clear got=%h/%b/%b exp=0/0000/0",
                         mem_req, req_grant, route_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_grant !== '0) begin
      n_fail++; $display("FAIL mid_first_cycle_grant got=%b exp=0000", req_grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req.vld !== 1'b0) begin
      n_fail++; $display("FAIL mid_first_cycle_mem_req got=%b exp=0", mem_req.vld);
    end
    @(negedge clk); #1;
    n_checks++;
    if (req_grant !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_winner got=%b exp=0001", req_grant);
    end
    @(negedge clk);
  endtask

  // Randomized traffic checked against a cycle-level behavioural model.
  task automatic test_random();
    int         m_out [N];
    int         m_lw;
    request_t   m_mem_req;
    request_t   m_rsp [N];
    logic       m_err;
    logic       free;
    int         win;
    int         j;
    int         cid;
    logic [N-1:0] exp_grant;
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0;
      m_rsp[i] = '0;
    end
    m_lw      = N - 1;
    m_mem_req = '0;
    m_err     = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // drive: requesters hold until granted; new ones appear at random
      mem_grant = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_in[i].vld && $urandom_range(0, 2) == 0)
          req_in[i] = mk_req(3'($urandom_range(0, 7)), 16'($urandom), $urandom);
      end
      cid = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0 && m_out[cid] > 0)
        mem_rsp = mk_req(3'(cid), 16'($urandom), $urandom);
      else
        mem_rsp = '0;

      // model: who wins this cycle
      free = !m_mem_req.vld || mem_grant;
      win  = -1;
      if (free) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_lw + k) % N;
          if (win < 0 && req_in[j].vld && m_out[j] < MAXO) win = j;
        end
      end
      exp_grant = (win >= 0) ? N'(1 << win) : '0;
      #1;
      n_checks++;
      if (req_grant !== exp_grant) begin
        n_fail++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_grant, exp_grant);
      end

      // model: state after the edge
      if (free) begin
        if (win >= 0) begin
          m_mem_req         = req_in[win];
          m_mem_req.core_id = 3'(win);
          m_mem_req.vld     = 1'b1;
        end else begin
          m_mem_req = '0;
        end
      end
      for (int i = 0; i < N; i++) m_rsp[i] = '0;
      if (win >= 0) begin
        m_out[win] = m_out[win] + 1;
        m_lw = win;
      end
      if (mem_rsp.vld) begin
        cid = int'(mem_rsp.core_id);
        if (cid < N) begin
          m_rsp[cid] = mem_rsp;
          if (m_out[cid] == 0) m_err = 1'b1;
          else m_out[cid] = m_out[cid] - 1;
        end else begin
          m_err = 1'b1;
        end
      end

      @(posedge clk); #1;
      n_checks++;
      if (mem_req !== m_mem_req) begin
        n_fail++; $display("FAIL rand_mem_req cyc=%0d got=%h exp=%h", cyc, mem_req, m_mem_req);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (rsp_out[i] !== m_rsp[i]) begin
          n_fail++; $display("FAIL rand_rsp_out[%0d] cyc=%0d got=%h exp=%h",
                             i, cyc, rsp_out[i], m_rsp[i]);
        end
      end
      n_checks++;
      if (route_err !== m_err) begin
        n_fail++; $display("FAIL rand_route_err cyc=%0d got=%b exp=%b", cyc, route_err, m_err);
      end
      @(negedge clk);
      if (win >= 0) req_in[win] = '0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_stall();
    test_outstanding_limit();
    test_same_cycle();
    test_route_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
